// File: rtl/wb_cfg_loader_pkg.sv
// Shared definitions for the Wishbone configuration loader: register map,
// CTRL/STATUS bit positions, FSM encodings and the STATUS packing helper.
package wb_cfg_loader_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LEN    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_EMPTY = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [5:0] WORD_BITS = 6'd32;

    function automatic logic [31:0] pack_status(input logic       busy,
                                                input logic       done,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [3:0] count);
        logic [31:0] s;
        s             = '0;
        s[STAT_BUSY]  = busy;
        s[STAT_DONE]  = done;
        s[STAT_FULL]  = full;
        s[STAT_EMPTY] = empty;
        s[11:8]       = count;
        return s;
    endfunction

endpackage

// File: rtl/wb_cfg_loader_fifo.sv
// Synchronous word FIFO feeding the configuration shift register; flush empties
// it in one cycle without touching the storage array.
module wb_cfg_loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: reset is synchronous (sampled on the clock edge), and every
    // register here is updated with <= so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count define validity,
    // which lets the array map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/wb_cfg_loader.sv
// Wishbone slave that buffers bitstream words and shifts them LSB-first into the
// fabric configuration chain, holding the fabric in reset until LEN bits are in.
module wb_cfg_loader
    import wb_cfg_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          LEN_W      = 20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cfg_bit_o,
    output logic        cfg_shift_o,
    output logic        cfg_done_o,
    output logic        fabric_rst_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       state;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      sr;
    logic [5:0]       sr_cnt;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      fifo_rdata;
    logic [CNT_W-1:0] fifo_count;

    logic             addr_hit;
    logic [1:0]       reg_idx;
    logic             req;
    logic             data_blocked;
    logic             bus_go;
    logic             wr_go;
    logic             rd_go;
    logic             start_cmd;
    logic             abort_cmd;
    logic             start_zero;
    logic             shift_active;
    logic             last_bit;
    logic             load_word;
    logic [31:0]      rd_value;
    logic             unused_ok;

    assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

    // A strobe is served at most once: the cycle ack is high never re-triggers.
    assign addr_hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_idx      = wbs_adr_i[3:2];
    assign req          = wbs_cyc_i & wbs_stb_i & addr_hit & ~wbs_ack_o;
    assign data_blocked = wbs_we_i && (reg_idx == REG_DATA) && fifo_full && (state != S_DONE);
    assign bus_go       = req & ~data_blocked;
    assign wr_go        = bus_go & wbs_we_i;
    assign rd_go        = bus_go & ~wbs_we_i;

    assign abort_cmd  = wr_go && (reg_idx == REG_CTRL) && wbs_dat_i[CTRL_ABORT];
    assign start_cmd  = wr_go && (reg_idx == REG_CTRL) && wbs_dat_i[CTRL_START]
                        && !wbs_dat_i[CTRL_ABORT];
    assign start_zero = start_cmd && (state == S_IDLE) && (len_reg == '0);

    assign shift_active = (state == S_SHIFT) && (sr_cnt != '0);
    assign last_bit     = shift_active && (remaining == LEN_W'(1));
    assign load_word    = (state == S_SHIFT) && (sr_cnt == '0) && !fifo_empty;

    assign fifo_push  = wr_go && (reg_idx == REG_DATA) && (state != S_DONE);
    assign fifo_pop   = load_word;
    assign fifo_flush = abort_cmd | last_bit | start_zero;

    wb_cfg_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (wbs_dat_i),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: rd_value gets a default before the case so no latch is inferred.
    always_comb begin
        rd_value = '0;
        case (reg_idx)
            REG_LEN:    rd_value = 32'(len_reg);
            REG_STATUS: rd_value = pack_status(state == S_SHIFT, state == S_DONE,
                                               fifo_full, fifo_empty, 4'(fifo_count));
            default:    rd_value = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            state     <= S_IDLE;
            len_reg   <= '0;
            remaining <= '0;
            sr        <= '0;
            sr_cnt    <= '0;
        end else begin
            wbs_ack_o <= bus_go;
            wbs_dat_o <= rd_go ? rd_value : '0;

            if (wr_go && (reg_idx == REG_LEN) && (state != S_SHIFT))
                len_reg <= wbs_dat_i[LEN_W-1:0];

            case (state)
                S_IDLE: begin
                    if (start_cmd) begin
                        if (len_reg == '0) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_SHIFT;
                            remaining <= len_reg;
                        end
                    end
                end
                S_SHIFT: begin
                    if (load_word) begin
                        sr     <= fifo_rdata;
                        sr_cnt <= WORD_BITS;
                    end else if (shift_active) begin
                        sr        <= {1'b0, sr[31:1]};
                        sr_cnt    <= sr_cnt - 6'd1;
                        remaining <= remaining - LEN_W'(1);
                        // Leftover bits of the current word are discarded here.
                        if (last_bit) begin
                            state  <= S_DONE;
                            sr_cnt <= '0;
                        end
                    end
                end
                default: begin
                    // DONE only leaves through abort.
                end
            endcase

            if (abort_cmd) begin
                state     <= S_IDLE;
                sr        <= '0;
                sr_cnt    <= '0;
                remaining <= '0;
            end
        end
    end

    assign cfg_shift_o  = shift_active;
    assign cfg_bit_o    = shift_active & sr[0];
    assign cfg_done_o   = (state == S_DONE);
    assign fabric_rst_o = (state != S_DONE);

endmodule

// File: tb/tb_wb_cfg_loader.sv
// Self-checking bench for wb_cfg_loader: register vector table plus scoreboarded
// shift sequences (stall, full FIFO, abort, zero length, reset mid-shift).
module tb_wb_cfg_loader;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_LEN  = BASE + 32'h4;
    localparam logic [31:0] A_DATA = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        cfg_bit_o;
    logic        cfg_shift_o;
    logic        cfg_done_o;
    logic        fabric_rst_o;

    wb_cfg_loader #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .LEN_W      (20)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_dat_o    (wbs_dat_o),
        .cfg_bit_o    (cfg_bit_o),
        .cfg_shift_o  (cfg_shift_o),
        .cfg_done_o   (cfg_done_o),
        .fabric_rst_o (fabric_rst_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        string       name;
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        logic        exp_ack;
        logic [31:0] exp_rdat;
    } vec_t;

    vec_t vecs[15];
    logic exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pulses   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // One clock; sampled 1 time unit after the edge, scoring any shift pulse.
    task automatic cycle();
        logic b;
        @(posedge wb_clk_i);
        #1;
        if (cfg_shift_o) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_shift", 32'(cfg_shift_o), 32'd0);
            end else begin
                b = exp_q.pop_front();
                check("cfg_bit", 32'(cfg_bit_o), 32'(b));
            end
        end
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input int budget, output logic acked, output logic [31:0] rdat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        acked     = 1'b0;
        rdat      = '0;
        for (int i = 0; i < budget && !acked; i++) begin
            cycle();
            if (wbs_ack_o) begin
                acked = 1'b1;
                rdat  = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] data, input string name);
        logic        acked;
        logic [31:0] rdat;
        wb_xfer(adr, 1'b1, data, 20, acked, rdat);
        check(name, 32'(acked), 32'd1);
    endtask

    task automatic rd_check(input logic [31:0] adr, input logic [31:0] exp, input string name);
        logic        acked;
        logic [31:0] rdat;
        wb_xfer(adr, 1'b0, 32'd0, 20, acked, rdat);
        check({name, "_ack"}, 32'(acked), 32'd1);
        check(name, rdat, exp);
    endtask

    task automatic push_word(input logic [31:0] w, input int nbits, input string name);
        for (int i = 0; i < nbits; i++) exp_q.push_back(w[i]);
        wr(A_DATA, w, name);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !cfg_done_o; i++) cycle();
    endtask

    task automatic wait_pulses(input int target, input int budget);
        for (int i = 0; i < budget && pulses < target; i++) cycle();
    endtask

    initial begin
        logic        acked;
        logic [31:0] rdat;
        logic [31:0] w;
        int          base;

        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = '0;
        wbs_dat_i = '0;

        vecs[0]  = '{"rd_status_rst",   A_STAT,        1'b0, 32'h0,         1'b1, 32'h0000_0008};
        vecs[1]  = '{"rd_len_rst",      A_LEN,         1'b0, 32'h0,         1'b1, 32'h0};
        vecs[2]  = '{"wr_len",          A_LEN,         1'b1, 32'h000A_BCDE, 1'b1, 32'h0};
        vecs[3]  = '{"rd_len",          A_LEN,         1'b0, 32'h0,         1'b1, 32'h000A_BCDE};
        vecs[4]  = '{"wr_len_wide",     A_LEN,         1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[5]  = '{"rd_len_trunc",    A_LEN,         1'b0, 32'h0,         1'b1, 32'h000F_FFFF};
        vecs[6]  = '{"rd_ctrl",         A_CTRL,        1'b0, 32'h0,         1'b1, 32'h0};
        vecs[7]  = '{"rd_data",         A_DATA,        1'b0, 32'h0,         1'b1, 32'h0};
        vecs[8]  = '{"rd_bad_adr",      32'h3000_0010, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{"wr_bad_adr",      32'h4000_0008, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[10] = '{"wr_data",         A_DATA,        1'b1, 32'h0000_1234, 1'b1, 32'h0};
        vecs[11] = '{"rd_status_cnt1",  A_STAT,        1'b0, 32'h0,         1'b1, 32'h0000_0100};
        vecs[12] = '{"wr_abort",        A_CTRL,        1'b1, 32'h0000_0002, 1'b1, 32'h0};
        vecs[13] = '{"rd_status_flush", A_STAT,        1'b0, 32'h0,         1'b1, 32'h0000_0008};
        vecs[14] = '{"rd_status_lowa",  BASE + 32'hD,  1'b0, 32'h0,         1'b1, 32'h0000_0008};

        repeat (3) cycle();
        check("rst_ack",        32'(wbs_ack_o),    32'd0);
        check("rst_dat",        wbs_dat_o,         32'd0);
        check("rst_cfg_bit",    32'(cfg_bit_o),    32'd0);
        check("rst_cfg_shift",  32'(cfg_shift_o),  32'd0);
        check("rst_cfg_done",   32'(cfg_done_o),   32'd0);
        check("rst_fabric_rst", 32'(fabric_rst_o), 32'd1);
        wb_rst_i = 1'b0;
        cycle();

        foreach (vecs[i]) begin
            wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].wdat, 6, acked, rdat);
            check({vecs[i].name, "_ack"}, 32'(acked), 32'(vecs[i].exp_ack));
            if (!vecs[i].we && vecs[i].exp_ack) check(vecs[i].name, rdat, vecs[i].exp_rdat);
        end

        // Two-word stream, then DONE-state behaviour.
        wr(A_LEN, 32'd64, "t1_len");
        push_word(32'hA5A5_0001, 32, "t1_push0");
        push_word(32'h0000_00FF, 32, "t1_push1");
        base = pulses;
        wr(A_CTRL, 32'h1, "t1_start");
        wait_done(300);
        check("t1_done",       32'(cfg_done_o),   32'd1);
        check("t1_fabric_rst", 32'(fabric_rst_o), 32'd0);
        check("t1_pulses",     pulses - base,     32'd64);
        check("t1_q_empty",    exp_q.size(),      32'd0);
        rd_check(A_STAT, 32'h0000_000A, "t1_status_done");
        wr(A_DATA, 32'hFFFF_FFFF, "t1_data_in_done");
        rd_check(A_STAT, 32'h0000_000A, "t1_status_dropped");
        wr(A_CTRL, 32'h1, "t1_start_in_done");
        check("t1_still_done", 32'(cfg_done_o), 32'd1);
        wr(A_CTRL, 32'h3, "t1_abort");
        check("t1_abort_done",   32'(cfg_done_o),   32'd0);
        check("t1_abort_fabric", 32'(fabric_rst_o), 32'd1);

        // Start with an empty FIFO: stall, resume, stall, finish at 40 bits.
        wr(A_LEN, 32'd40, "t2_len");
        base = pulses;
        wr(A_CTRL, 32'h1, "t2_start");
        repeat (50) cycle();
        check("t2_stall_pulses", pulses - base, 32'd0);
        rd_check(A_STAT, 32'h0000_0009, "t2_status_stall");
        push_word(32'h1357_9BDF, 32, "t2_push0");
        repeat (40) cycle();
        check("t2_mid_pulses", pulses - base,    32'd32);
        check("t2_stalled",    32'(cfg_shift_o), 32'd0);
        push_word(32'hC3C3_3C3C, 8, "t2_push1");
        wait_done(100);
        check("t2_done",    32'(cfg_done_o), 32'd1);
        check("t2_pulses",  pulses - base,   32'd40);
        check("t2_q_empty", exp_q.size(),    32'd0);
        wr(A_CTRL, 32'h2, "t2_abort");

        // Fifth push into a full FIFO is withheld until the first pop.
        wr(A_LEN, 32'd160, "t3_len");
        for (int k = 0; k < 4; k++) begin
            w = 32'hF0E1_D2C3 ^ (32'(k) * 32'h1111_1111);
            push_word(w, 32, "t3_push");
        end
        rd_check(A_STAT, 32'h0000_0404, "t3_status_full");
        wb_xfer(A_DATA, 1'b1, 32'h8765_4321, 6, acked, rdat);
        check("t3_5th_withheld", 32'(acked), 32'd0);
        base = pulses;
        wr(A_CTRL, 32'h1, "t3_start");
        push_word(32'h8765_4321, 32, "t3_push5");
        wait_done(400);
        check("t3_done",    32'(cfg_done_o), 32'd1);
        check("t3_pulses",  pulses - base,   32'd160);
        check("t3_q_empty", exp_q.size(),    32'd0);
        wr(A_CTRL, 32'h2, "t3_abort");

        // Abort part-way through, then a fresh stream.
        wr(A_LEN, 32'd96, "t4_len");
        push_word(32'h0F0F_1234, 32, "t4_push0");
        push_word(32'hFFFF_0000, 32, "t4_push1");
        push_word(32'h8000_0001, 32, "t4_push2");
        base = pulses;
        wr(A_CTRL, 32'h1, "t4_start");
        wait_pulses(base + 10, 100);
        check("t4_shifting", 32'(cfg_shift_o), 32'd1);
        wr(A_CTRL, 32'h2, "t4_abort");
        check("t4_abort_shift",  32'(cfg_shift_o),  32'd0);
        check("t4_abort_fabric", 32'(fabric_rst_o), 32'd1);
        exp_q.delete();
        rd_check(A_STAT, 32'h0000_0008, "t4_status_idle");
        push_word(32'h6B6B_A1A1, 32, "t4_push3");
        push_word(32'h0000_0001, 32, "t4_push4");
        push_word(32'hFEDC_BA98, 32, "t4_push5");
        base = pulses;
        wr(A_CTRL, 32'h1, "t4_restart");
        wait_done(300);
        check("t4_done",    32'(cfg_done_o), 32'd1);
        check("t4_pulses",  pulses - base,   32'd96);
        check("t4_q_empty", exp_q.size(),    32'd0);
        wr(A_CTRL, 32'h2, "t4_abort2");

        // Zero length goes straight to DONE; undecoded address never acks.
        wr(A_LEN, 32'd0, "t5_len");
        base = pulses;
        wr(A_CTRL, 32'h1, "t5_start");
        check("t5_done_now",   32'(cfg_done_o),   32'd1);
        check("t5_fabric_rst", 32'(fabric_rst_o), 32'd0);
        repeat (3) cycle();
        check("t5_no_pulses", pulses - base, 32'd0);
        wb_xfer(32'h3000_0020, 1'b0, 32'd0, 8, acked, rdat);
        check("t5_bad_adr_timeout", 32'(acked), 32'd0);
        wr(A_CTRL, 32'h2, "t5_abort");

        // Synchronous reset in the middle of a shift.
        wr(A_LEN, 32'd64, "t6_len");
        push_word(32'h2468_ACE0, 32, "t6_push0");
        push_word(32'h1111_2222, 32, "t6_push1");
        base = pulses;
        wr(A_CTRL, 32'h1, "t6_start");
        wait_pulses(base + 5, 100);
        check("t6_shifting", 32'(cfg_shift_o), 32'd1);
        wb_rst_i = 1'b1;
        cycle();
        check("t6_ack",        32'(wbs_ack_o),    32'd0);
        check("t6_dat",        wbs_dat_o,         32'd0);
        check("t6_cfg_bit",    32'(cfg_bit_o),    32'd0);
        check("t6_cfg_shift",  32'(cfg_shift_o),  32'd0);
        check("t6_cfg_done",   32'(cfg_done_o),   32'd0);
        check("t6_fabric_rst", 32'(fabric_rst_o), 32'd1);
        wb_rst_i = 1'b0;
        exp_q.delete();
        rd_check(A_STAT, 32'h0000_0008, "t6_status");
        rd_check(A_LEN,  32'h0,         "t6_len_cleared");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
